// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: load-use and multi-cycle
// stalls, MMIO wait holds, redirect flushes, operand forwarding and saturating counters.
module pipe_hazard_unit #(
  parameter int AW          = 5,
  parameter int MEM_LAT     = 1,
  parameter int FLUSH_DEPTH = 3,
  parameter int MC_MAX      = 34,
  parameter int CW          = 6,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [AW-1:0]    ex_rs1,
  input  logic [AW-1:0]    ex_rs2,
  input  logic [AW-1:0]    ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [AW-1:0]    mem_rd,
  input  logic             mem_regwrite,
  input  logic [AW-1:0]    wb_rd,
  input  logic             wb_regwrite,
  input  logic             mc_start,
  input  logic [CW-1:0]    mc_lat,
  input  logic             redirect,
  input  logic             io_wait,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             hold_ex,
  output logic             hold_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [2:0]    LU_INIT = 3'(MEM_LAT - 1);
  localparam logic [CW-1:0] MC_CAP  = CW'(MC_MAX);

  logic [2:0]    lu_cnt;
  logic [CW-1:0] mc_cnt;
  logic [CW-1:0] mc_eff;
  logic          lu_hit;
  logic          lu_stall;
  logic          redirect_acc;

  // MEM result is younger than WB data, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                         input logic [AW-1:0] m_rd, input logic m_we,
                                         input logic [AW-1:0] w_rd, input logic w_we);
    if (src == '0)                return 2'b00;
    else if (m_we && src == m_rd) return 2'b01;
    else if (w_we && src == w_rd) return 2'b10;
    else                          return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  assign lu_hit = ex_memread & ex_regwrite & (ex_rd != '0) &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  assign lu_stall     = (lu_cnt != 3'd0) | lu_hit;
  assign mc_busy      = (mc_cnt != '0);
  assign redirect_acc = redirect & ~io_wait & ~rst;
  assign mc_eff       = (mc_lat > MC_CAP) ? MC_CAP : mc_lat;

  assign fwd_a = rst ? 2'b00 : fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
  assign fwd_b = rst ? 2'b00 : fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);

  // Priority: io_wait > redirect > mc_busy > load-use; reset masks everything at once.
  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    bubble_ex    = 1'b0;
    hold_ex      = 1'b0;
    hold_mem     = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    if (rst) begin
      stall_if = 1'b0;
    end else if (io_wait) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      hold_ex  = 1'b1;
      hold_mem = 1'b1;
    end else if (redirect) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = (FLUSH_DEPTH >= 2);
      flush_ex_mem = (FLUSH_DEPTH >= 3);
    end else if (mc_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      hold_ex  = 1'b1;
    end else if (lu_stall) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt       <= 3'd0;
      mc_cnt       <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      stall_cycles <= sat_inc(stall_cycles, stall_if);
      flush_events <= sat_inc(flush_events, redirect_acc);
      if (io_wait) begin
        lu_cnt <= lu_cnt;
        mc_cnt <= mc_cnt;
      end else if (redirect) begin
        lu_cnt <= 3'd0;
        mc_cnt <= '0;
      end else if (mc_busy) begin
        // A load-use hit seen while busy is re-evaluated once busy ends.
        mc_cnt <= mc_cnt - CW'(1);
      end else begin
        if (lu_cnt != 3'd0)  lu_cnt <= lu_cnt - 3'd1;
        else if (lu_hit)     lu_cnt <= LU_INIT;
        if (mc_start && mc_eff >= CW'(2)) mc_cnt <= mc_eff - CW'(1);
      end
    end
  end

  a_mc_start_idle: assert property (@(posedge clk) disable iff (rst) !(mc_start && mc_busy))
    else $error("mc_start while multi-cycle op busy");
  a_redirect_io: assert property (@(posedge clk) disable iff (rst) !(redirect && io_wait))
    else $error("redirect together with io_wait");

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
- Successor to the single-bubble Pause/Flush scheme:
  - configurable load latency (multi-cycle stalls);
  - multi-cycle EX operations (divider) with a busy countdown;
  - MMIO wait-state stalls;
  - configurable flush depth;
  - saturating performance counters.
- Sits beside the pipeline registers. Drives their hold/bubble/flush inputs and the ALU operand forwarding muxes.

Parameters:
AW, 5, register address width
MEM_LAT, 1, cycles from load in EX until its data is forwardable from WB (1..4)
FLUSH_DEPTH, 3, number of younger stages flushed on redirect (1=IF/ID, 2=+ID/EX, 3=+EX/MEM)
MC_MAX, 34, maximum multi-cycle EX latency
CW, 6, width of mc_lat (>= clog2(MC_MAX+1))
CNT_W, 32, performance counter width

Ports:
clk  in  1  CPU clock
rst  in  1  reset, asynchronous, active-high
id_rs1, id_rs2  in  AW  ID-stage source registers
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads the source
ex_rs1, ex_rs2  in  AW  EX-stage sources (forwarding)
ex_rd  in  AW  EX destination
ex_regwrite, ex_memread  in  1  EX writes rd / is a load
mem_rd  in  AW; mem_regwrite  in  1  MEM destination/valid
wb_rd  in  AW; wb_regwrite  in  1  WB destination/valid
mc_start  in  1  multi-cycle op enters EX this cycle
mc_lat  in  CW  its latency in cycles
redirect  in  1  taken branch/jump resolved in MEM
io_wait  in  1  MMIO access in MEM not ready
stall_if, stall_id  out  1  hold PC and IF/ID
bubble_ex  out  1  load NOP into ID/EX
hold_ex, hold_mem  out  1  hold ID/EX, EX/MEM
flush_if_id, flush_id_ex, flush_ex_mem  out  1  clear stage
fwd_a, fwd_b  out  2  00 regfile, 01 MEM ALUResult, 10 WB data
mc_busy  out  1  multi-cycle op in progress
stall_cycles, flush_events  out  CNT_W  performance counters

Behaviour:
- Reset (async, immediate):
  - lu_cnt=0, mc_cnt=0, counters=0.
  - All stall/hold/flush/bubble outputs 0, fwd_a/fwd_b=00.
- Forwarding (combinational), per operand:
  - src==0 -> 00.
  - src==mem_rd && mem_regwrite -> 01.
  - src==wb_rd && wb_regwrite -> 10.
  - Otherwise 00. MEM beats WB.
- Load-use detect: lu_hit = ex_memread & ex_regwrite & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Load-use stall:
  - When lu_cnt==0 and lu_hit: stall_if=stall_id=bubble_ex=1 this cycle; lu_cnt <= MEM_LAT-1.
  - While lu_cnt>0: same outputs, then decrement.
  - Total stall is exactly MEM_LAT cycles.
- Multi-cycle ops:
  - mc_start with mc_lat>=2 -> mc_cnt <= mc_lat-1 next cycle.
  - mc_busy = mc_cnt!=0. While busy: stall_if=stall_id=hold_ex=1; mc_cnt decrements.
  - mc_lat 0 or 1: no busy.
  - mc_start while busy is illegal (assertion); it is ignored.
  - mc_lat>MC_MAX is clamped to MC_MAX.
- io_wait: stall_if=stall_id=hold_ex=hold_mem=1 while high. lu_cnt and mc_cnt are frozen.
- Redirect:
  - Asserts flush_if_id, plus flush_id_ex if FLUSH_DEPTH>=2, plus flush_ex_mem if FLUSH_DEPTH>=3, for that cycle only.
  - Clears lu_cnt and mc_cnt next edge.
  - Suppresses stall/bubble/hold outputs that cycle.
- Priority: io_wait > redirect > mc_busy > load-use.
  - redirect together with io_wait is illegal (assertion); io_wait wins and the redirect is dropped.
  - lu_hit during mc_busy is not registered until busy ends; it is re-evaluated then.
- Counters:
  - stall_cycles +1 on each cycle with stall_if=1.
  - flush_events +1 on each accepted redirect.
  - Both saturate at all-ones, with no wrap.
- Reset mid-stall: all counters and outputs return to 0 immediately; the pipeline restarts without residual stall.

Test Plan:
1. MEM_LAT=1: load x5 in EX, ID add uses x5 -> stall_if/bubble_ex high exactly 1 cycle; next cycle fwd_a=10 for x5.
2. MEM_LAT=3: same stimulus -> stall for 3 consecutive cycles; stall_cycles=3 afterwards.
3. Forwarding: mem_rd=wb_rd=7, both regwrite, ex_rs1=7 -> fwd_a=01. ex_rs2=0 with mem_rd=0 -> fwd_b=00.
4. mc_start, mc_lat=34 -> mc_busy/hold_ex high 33 cycles. Redirect at busy cycle 10 -> flush_* pulse 1 cycle (all three at FLUSH_DEPTH=3); mc_busy 0 next cycle; flush_events=1.
5. io_wait high 5 cycles during 3-cycle load-use stall -> all holds high; lu_cnt frozen; stall finishes after io_wait drops; stall_cycles=8.
6. rst pulse mid mc_busy -> all outputs 0 same cycle. Counter saturation with CNT_W=4: 20 stall cycles -> stall_cycles=15.
